pipe_ex_cond_stage: RTL
=======================

# pipe_ex_cond_stage

Execute-stage control block of the ARM-subset pipeline, directly downstream of the decode-stage main/ALU decoders. It holds the ID/EX control pipeline register, including flush, stall and a valid bit. It evaluates the instruction's condition field against the architectural NZCV flags register and updates NZCV from the ALU. It drives the condition-gated control set into the EX/MEM register and the PC-select mux.

## Interface
Parameters:
- WA_W, 4, width of destination register address carried to later stages

Ports:
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- RegW_D, MemW_D, MemtoReg_D, ALUSrc_D, Branch_D, PCS_D  in  1 each  decode-stage controls (PCS_D = data-processing write to R15)
- ALUControl_D  in  2  ALU operation from the ALU decoder
- FlagW_D  in  2  [1] = write N,Z; [0] = write C,V
- Cond_D  in  4  instruction bits [31:28]
- WA3_D  in  WA_W  destination register
- FlushE  in  1  insert a bubble into EX at next edge
- StallE  in  1  hold the EX instruction
- ALUFlags_E  in  4  {N,Z,C,V} from the ALU for the EX instruction
- RegW_E, MemW_E, PCSrc_E  out  1 each  condition-gated controls
- MemtoReg_E, ALUSrc_E  out  1 each  registered pass-through
- ALUControl_E  out  2  registered pass-through
- WA3_E  out  WA_W  registered pass-through
- CondEx_E  out  1  condition passed and the instruction is valid
- Flags  out  4  architectural {N,Z,C,V}

## Operation
- ID/EX register holds valid_E plus all *_D controls, FlagW, Cond and WA3.
- Register update priority on each rising clk:
  - FlushE=1: load a bubble (valid_E=0, all controls 0, Cond=1110, WA3=0).
  - Else StallE=1: hold the current contents.
  - Else: load the *_D inputs with valid_E=1.
- Condition evaluation is combinational from Cond_E and the current Flags register.
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL 1, and 1111 evaluates to 0.
- CondEx_E = condition result & valid_E & ~StallE.
- Gated outputs:
  - RegW_E = RegW & CondEx_E
  - MemW_E = MemW & CondEx_E
  - PCSrc_E = (PCS | Branch) & CondEx_E
- A stalled EX therefore presents a bubble to EX/MEM in every stall cycle. The real instruction issues in the first cycle after StallE deasserts.
- Flags register write at the rising clk, only when CondEx_E=1:
  - N,Z take ALUFlags_E[3:2] if FlagW[1].
  - C,V take ALUFlags_E[1:0] if FlagW[0].
  - Unwritten bits hold.
- Reset (asynchronous, reset_n low):
  - valid_E=0, all registered controls 0, Cond=1110, WA3=0, Flags=0000.
  - Every output is therefore 0 during and immediately after reset.

## Timing
- Latency: *_D inputs sampled at edge k appear on the *_E outputs during cycle k+1. Gated outputs are combinational from the register and Flags within that cycle.
- A flag-setting instruction in EX during cycle k affects the condition of the instruction in EX during cycle k+1 (back-to-back). No forwarding bypass is needed.
- Simultaneous FlushE and StallE: the flush wins, and the held instruction is discarded.
- Stall with a flag-setting instruction: Flags are not written until the stall-release cycle, which happens exactly once.
- Reset asserted mid-operation: state clears immediately, with no partial flag update.
- FlagW on a failed-condition or bubble instruction has no effect.

## Structure
- Shared package pipe_pkg:
  - cond_e enum (EQ..AL, NV=1111).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - ex_ctrl_t packed struct for the ID/EX control fields, used for bubble constant BUBBLE_CTRL.
- One sub-module, pipe_cond_check: purely combational; inputs Cond[3:0] and Flags[3:0], output CondEx.
- The top level contains the ID/EX register, the Flags register and the gating.

## Test plan
- Reset: hold reset_n=0 with arbitrary D inputs, then release -> all outputs 0 and Flags=0000 until the first load edge.
- Flag set then use: issue SUBS (FlagW_D=11, Cond 1110) with ALUFlags_E=0100, then BEQ (Branch_D=1, Cond 0000) -> Flags=0100 after the first EX cycle; PCSrc_E=1 and CondEx_E=1 for the BEQ.
- Failed condition:
  - Stimulus: Flags=0000; issue STR (MemW_D=1, Cond 0000) with FlagW_D=11 and ALUFlags_E=1111.
  - Response: MemW_E=0, RegW_E=0, and Flags remain 0000.
- Partial update: Flags=0000; issue FlagW_D=01 with ALUFlags_E=1111 -> Flags=0011.
- Stall/flush:
  - Stall path: hold StallE=1 for 2 cycles on a flag-setting ADDS -> RegW_E=0 in both stall cycles; in the release cycle RegW_E=1 and Flags update once.
  - Combined assert: FlushE=StallE=1 -> next cycle valid_E=0 and all outputs 0.
- Condition sweep: for all 16 Cond values × all 16 Flags values, CondEx_E matches the table in Operation. Cond 1111 always gives 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the EX-stage control slice: condition codes,
// NZCV bit positions and the ID/EX control bundle.
package pipe_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001,
    CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101,
    VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001,
    GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101,
    AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       pcs;
    logic [1:0] aluctrl;
    logic [1:0] flagw;
    cond_e      cond;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:    1'b0,
    regw:     1'b0,
    memw:     1'b0,
    memtoreg: 1'b0,
    alusrc:   1'b0,
    branch:   1'b0,
    pcs:      1'b0,
    aluctrl:  2'b00,
    flagw:    2'b00,
    cond:     AL
  };

endpackage

// File: rtl/pipe_cond_check.sv
// Combinational condition evaluator.
// Ports: Cond (instr[31:28]), Flags {N,Z,C,V} -> CondEx.
module pipe_cond_check
  import pipe_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    unique case (cond_e'(Cond))
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ex_cond_stage.sv
// EX-stage control: ID/EX register with flush/stall, NZCV register,
// condition gating of RegW/MemW/PCSrc toward EX/MEM and the PC mux.
module pipe_ex_cond_stage
  import pipe_pkg::*;
#(
  parameter int WA_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            RegW_D,
  input  logic            MemW_D,
  input  logic            MemtoReg_D,
  input  logic            ALUSrc_D,
  input  logic            Branch_D,
  input  logic            PCS_D,
  input  logic [1:0]      ALUControl_D,
  input  logic [1:0]      FlagW_D,
  input  logic [3:0]      Cond_D,
  input  logic [WA_W-1:0] WA3_D,
  input  logic            FlushE,
  input  logic            StallE,
  input  logic [3:0]      ALUFlags_E,
  output logic            RegW_E,
  output logic            MemW_E,
  output logic            PCSrc_E,
  output logic            MemtoReg_E,
  output logic            ALUSrc_E,
  output logic [1:0]      ALUControl_E,
  output logic [WA_W-1:0] WA3_E,
  output logic            CondEx_E,
  output logic [3:0]      Flags
);

  ex_ctrl_t        ctrl_q, ctrl_d;
  logic [WA_W-1:0] wa3_q, wa3_d;
  logic [3:0]      flags_q, flags_d;
  logic            cond_ok;

  always_comb begin
    ctrl_d = ctrl_q;
    wa3_d  = wa3_q;
    if (FlushE) begin
      ctrl_d = BUBBLE_CTRL;
      wa3_d  = '0;
    end else if (!StallE) begin
      ctrl_d.valid    = 1'b1;
      ctrl_d.regw     = RegW_D;
      ctrl_d.memw     = MemW_D;
      ctrl_d.memtoreg = MemtoReg_D;
      ctrl_d.alusrc   = ALUSrc_D;
      ctrl_d.branch   = Branch_D;
      ctrl_d.pcs      = PCS_D;
      ctrl_d.aluctrl  = ALUControl_D;
      ctrl_d.flagw    = FlagW_D;
      ctrl_d.cond     = cond_e'(Cond_D);
      wa3_d           = WA3_D;
    end
  end

  pipe_cond_check u_cond (
    .Cond   (ctrl_q.cond),
    .Flags  (flags_q),
    .CondEx (cond_ok)
  );

  // A stalled instruction is shown as a bubble each stall cycle,
  // so it cannot write state until the release cycle.
  assign CondEx_E = cond_ok & ctrl_q.valid & ~StallE;

  always_comb begin
    flags_d = flags_q;
    if (CondEx_E) begin
      if (ctrl_q.flagw[1]) begin
        flags_d[FLAG_N] = ALUFlags_E[FLAG_N];
        flags_d[FLAG_Z] = ALUFlags_E[FLAG_Z];
      end
      if (ctrl_q.flagw[0]) begin
        flags_d[FLAG_C] = ALUFlags_E[FLAG_C];
        flags_d[FLAG_V] = ALUFlags_E[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= BUBBLE_CTRL;
      wa3_q   <= '0;
      flags_q <= 4'b0000;
    end else begin
      ctrl_q  <= ctrl_d;
      wa3_q   <= wa3_d;
      flags_q <= flags_d;
    end
  end

  assign RegW_E       = ctrl_q.regw & CondEx_E;
  assign MemW_E       = ctrl_q.memw & CondEx_E;
  assign PCSrc_E      = (ctrl_q.pcs | ctrl_q.branch) & CondEx_E;
  assign MemtoReg_E   = ctrl_q.memtoreg;
  assign ALUSrc_E     = ctrl_q.alusrc;
  assign ALUControl_E = ctrl_q.aluctrl;
  assign WA3_E        = wa3_q;
  assign Flags        = flags_q;

endmodule
